uart_tx_serializer: RTL and testbench

- UART transmit engine; the outbound counterpart of the receive-side baud/sample generator.
- Accepts a byte on a one-cycle start strobe and drives one serial frame on tx_out: start bit, 8 data bits LSB-first, optional parity bit, one stop bit.
- Bit timing comes from an internal baud divider clocked by sysclk.
- Sits between the CPU's UART peripheral register block and the board TX pin.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx_serializer.sv | 124 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 10416;  // 100 MHz / 9600 baud
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned BAUD_CNT_W           = 16;     // covers CLKS_PER_BIT up to 65535

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period divider: counts 0..CLKS_PER_BIT-1, pulses tick on
// the terminal count, and restarts from 0 on a synchronous clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  tick,
  output logic [BAUD_CNT_W-1:0] cnt
);

  localparam logic [BAUD_CNT_W-1:0] TERM = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap on terminal count or clear.
  always_comb begin
    cnt_d = cnt_q + BAUD_CNT_W'(1);
    if (clr || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM) && !clr;
  assign cnt  = cnt_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, 8 data bits LSB-first, optional parity,
// one stop bit. All outputs are registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [BAUD_CNT_W-1:0] PRE_TERM = BAUD_CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]            LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_out_q, tx_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_tick;
  logic [BAUD_CNT_W-1:0]  baud_cnt;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk  (sysclk),
    .rst  (reset),
    .clr  (state_q == ST_IDLE),
    .tick (baud_tick),
    .cnt  (baud_cnt)
  );

  // Next-state, datapath and registered-output lookahead.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ PARITY_ODD;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are computed from the state being
    // entered; tx_done is raised one cycle early so it lands on the final
    // stop-bit cycle, and tx_busy drops in that same cycle.
    unique case (state_d)
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shift_d[0];
      ST_PARITY: tx_out_d = parity_d;
      default:   tx_out_d = 1'b1;
    endcase

    done_d = (state_q == ST_STOP) && (baud_cnt == PRE_TERM);
    busy_d = (state_d != ST_IDLE) && !done_d;
  end

  // State and output registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four configurations share stimulus.
// Cycle k means the interval after the k-th rising edge following acceptance.
module tb_uart_tx_serializer;

  logic       sysclk;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;

  logic out_a, busy_a, done_a;  // CLKS=4, no parity
  logic out_e, busy_e, done_e;  // CLKS=4, even parity
  logic out_o, busy_o, done_o;  // CLKS=4, odd parity
  logic out_f, busy_f, done_f;  // CLKS=2, no parity

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_plain (
    .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_out(out_e), .tx_busy(busy_e), .tx_done(done_e));

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_out(out_o), .tx_busy(busy_o), .tx_done(done_o));

  uart_tx_serializer #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_fast (
    .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_out(out_f), .tx_busy(busy_f), .tx_done(done_f));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Expected line level in cycle k for a frame whose bit i (in time order) is fr[i].
  function automatic logic exp_line(input logic [10:0] fr, input int nbits,
                                    input int cpb, input int k);
    if (k < 1 || k > nbits * cpb) return 1'b1;
    return fr[(k - 1) / cpb];
  endfunction

  // Present a one-cycle start request; returns at the sample point of cycle 1.
  task automatic start_pulse(input logic [7:0] d);
    @(negedge sysclk);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_a | busy_e | busy_o | busy_f) && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    vec_cnt++;
    if (busy_a | busy_e | busy_o | busy_f) begin
      miscmp_cnt++;
      $display("FAIL idle_timeout busy=%b exp=0000", {busy_a, busy_e, busy_o, busy_f});
    end
    repeat (3) @(negedge sysclk);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge sysclk);
    got = {out_a, busy_a, done_a, out_e, busy_e, done_e,
           out_o, busy_o, done_o, out_f, busy_f, done_f};
    vec_cnt++;
    if (got !== 12'b100_100_100_100) begin
      miscmp_cnt++;
      $display("FAIL reset_state got=%b exp=100100100100", got);
    end
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    got = {out_a, busy_a, done_a, out_e, busy_e, done_e,
           out_o, busy_o, done_o, out_f, busy_f, done_f};
    vec_cnt++;
    if (got !== 12'b100_100_100_100) begin
      miscmp_cnt++;
      $display("FAIL idle_after_reset got=%b exp=100100100100", got);
    end
  endtask

  // 0x55, no parity: 0,1,0,1,0,1,0,1,0,1 in time order.
  task automatic test_basic_frame();
    logic [2:0] got, exp;
    start_pulse(8'h55);
    for (int k = 1; k <= 42; k++) begin
      if (k > 1) @(negedge sysclk);
      got = {out_a, busy_a, done_a};
      exp = {exp_line(11'h2AA, 10, 4, k), (k <= 39), (k == 40)};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL basic_55 cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
    end
    wait_idle();
  endtask

  // 0x07 with parity: data 1,1,1,0,0,0,0,0; even parity bit 1, odd parity bit 0.
  task automatic test_parity();
    logic [2:0] got, exp;
    start_pulse(8'h07);
    for (int k = 1; k <= 46; k++) begin
      if (k > 1) @(negedge sysclk);
      got = {out_e, busy_e, done_e};
      exp = {exp_line(11'h60E, 11, 4, k), (k <= 43), (k == 44)};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL parity_even cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
      got = {out_o, busy_o, done_o};
      exp = {exp_line(11'h40E, 11, 4, k), (k <= 43), (k == 44)};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL parity_odd cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
    end
    wait_idle();
  endtask

  // A start request and new data mid-frame must neither alter nor queue anything.
  task automatic test_ignore_busy();
    logic [2:0] got, exp;
    start_pulse(8'h00);
    for (int k = 1; k <= 52; k++) begin
      if (k > 1) @(negedge sysclk);
      got = {out_a, busy_a, done_a};
      exp = {exp_line(11'h200, 10, 4, k), (k <= 39), (k == 40)};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL ignore_busy cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
      if (k == 15) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end
      if (k == 16) tx_start = 1'b0;
    end
    wait_idle();
  endtask

  // tx_start held high: second frame starts in cycle 42, after one idle cycle.
  task automatic test_back_to_back();
    logic [2:0] got, exp;
    int         k2;
    logic       ln;
    @(negedge sysclk);
    tx_data  = 8'hA3;
    tx_start = 1'b1;
    @(posedge sysclk);
    for (int k = 1; k <= 86; k++) begin
      @(negedge sysclk);
      k2 = k - 41;
      ln = (k <= 41) ? exp_line(11'h346, 10, 4, k) : exp_line(11'h346, 10, 4, k2);
      exp = {ln, ((k >= 1 && k <= 39) || (k2 >= 1 && k2 <= 39)), (k == 40 || k == 81)};
      got = {out_a, busy_a, done_a};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL back_to_back cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
      if (k == 60) tx_start = 1'b0;
    end
    wait_idle();
  endtask

  // Reset during data bit 3 aborts at once; a following 0x81 frame is clean.
  task automatic test_reset_abort();
    logic [2:0] got, exp;
    start_pulse(8'h00);
    for (int k = 2; k <= 18; k++) @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    got = {out_a, busy_a, done_a};
    vec_cnt++;
    if (got !== 3'b100) begin
      miscmp_cnt++;
      $display("FAIL async_reset_abort {out,busy,done} got=%b exp=100", got);
    end
    @(negedge sysclk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sysclk);
      got = {out_a, busy_a, done_a};
      vec_cnt++;
      if (got !== 3'b100) begin
        miscmp_cnt++;
        $display("FAIL post_abort_idle cyc=%0d {out,busy,done} got=%b exp=100", k, got);
      end
    end
    start_pulse(8'h81);
    for (int k = 1; k <= 42; k++) begin
      if (k > 1) @(negedge sysclk);
      got = {out_a, busy_a, done_a};
      exp = {exp_line(11'h302, 10, 4, k), (k <= 39), (k == 40)};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL after_abort_81 cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
    end
    wait_idle();
  endtask

  // CLKS_PER_BIT=2 with 0xC3: 20-cycle frame, byte rebuilt by a line sampler.
  task automatic test_min_divider();
    logic [2:0] got, exp;
    logic [7:0] cap;
    cap = '0;
    start_pulse(8'hC3);
    for (int k = 1; k <= 22; k++) begin
      if (k > 1) @(negedge sysclk);
      got = {out_f, busy_f, done_f};
      exp = {exp_line(11'h386, 10, 2, k), (k <= 19), (k == 20)};
      vec_cnt++;
      if (got !== exp) begin
        miscmp_cnt++;
        $display("FAIL min_div_C3 cyc=%0d {out,busy,done} got=%b exp=%b", k, got, exp);
      end
      if (k >= 3 && k <= 17 && (k % 2) == 1) cap[(k - 3) / 2] = out_f;
    end
    vec_cnt++;
    if (cap !== 8'hC3) begin
      miscmp_cnt++;
      $display("FAIL min_div_sampled_byte got=%h exp=c3", cap);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_min_divider();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
